// File: rtl/data_sram_slave.sv
// data_sram_slave: single-outstanding data-side memory responder for the MIPS core.
// It accepts one load/store, waits LATENCY edges, then answers with data_ok.
// Byte, halfword and word stores are supported, and misaligned accesses raise err.
// Optional build macro DSRAM_BACKPRESSURE_EN gates addr_ok with an alternating
// toggle so that the core's stall path gets exercised.
module data_sram_slave #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);
    localparam bit         SINGLE   = (LATENCY == 1);

    state_t              state;
    state_t              nextState;
    logic [3:0]          latCnt;

    // request captured at accept; inputs are ignored after that
    logic                wrQ;
    logic [1:0]          sizeQ;
    logic [ADDR_W+1:0]   addrQ;
    logic [31:0]         wdataQ;

    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                enterResp;
    logic                curWr;
    logic [1:0]          curSize;
    logic [ADDR_W+1:0]   curAddr;
    logic [31:0]         curWdata;
    logic                curErr;
    logic [3:0]          curBe;
    logic [ADDR_W-1:0]   curIdx;

    // halfword must be even, word must be 4-aligned, size 3 is reserved
    function automatic logic isBadAccess(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // little-endian byte lane enables for an aligned access
    function automatic logic [3:0] byteEnables(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // address bits above the word index alias by wrap-around
    generate
        if (ADDR_W + 2 <= 31) begin : gIgnoreHigh
            logic unusedAddrHigh;
            assign unusedAddrHigh = ^addr[31:ADDR_W+2];
        end
    endgenerate

`ifdef DSRAM_BACKPRESSURE_EN
    logic toggle;

    // free-running toggle: accepts only possible on every other cycle
    always_ff @(posedge clk) begin
        if (rst) toggle <= 1'b0;
        else     toggle <= ~toggle;
    end

    assign addr_ok = (state != WAIT) && toggle;
`else
    assign addr_ok = (state != WAIT);
`endif

    assign data_ok   = (state == RESP);
    assign accept    = req && addr_ok;
    assign enterResp = (nextState == RESP);

    // with LATENCY=1 the access happens on the accept edge, before the latch updates
    assign curWr    = (state == WAIT) ? wrQ    : wr;
    assign curSize  = (state == WAIT) ? sizeQ  : size;
    assign curAddr  = (state == WAIT) ? addrQ  : addr[ADDR_W+1:0];
    assign curWdata = (state == WAIT) ? wdataQ : wdata;
    assign curErr   = isBadAccess(curSize, curAddr[1:0]);
    assign curBe    = byteEnables(curSize, curAddr[1:0]);
    assign curIdx   = curAddr[ADDR_W+1:2];

    // next-state decode for the accept / wait / respond handshake
    always_comb begin
        nextState = state;
        case (state)
            IDLE, RESP: begin
                if (accept) nextState = SINGLE ? RESP : WAIT;
                else        nextState = IDLE;
            end
            WAIT: begin
                if (latCnt == 4'd1) nextState = RESP;
            end
            default: nextState = IDLE;
        endcase
    end

    // state register and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            latCnt <= 4'd0;
        end else begin
            state <= nextState;
            if (accept)             latCnt <= LOAD_CNT;
            else if (state == WAIT) latCnt <= latCnt - 4'd1;
        end
    end

    // capture the request fields at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            wrQ    <= wr;
            sizeQ  <= size;
            addrQ  <= addr[ADDR_W+1:0];
            wdataQ <= wdata;
        end
    end

    // response registers: load data or zero on error, err updated per completion
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (enterResp) begin
            err <= curErr;
            if (curErr)      rdata <= 32'd0;
            else if (!curWr) rdata <= mem[curIdx];
        end
    end

    // store commit on the RESP-entry edge; reset on that edge suppresses it
    always_ff @(posedge clk) begin
        if (!rst && enterResp && curWr && !curErr) begin
            for (int i = 0; i < 4; i++) begin
                if (curBe[i]) mem[curIdx][8*i +: 8] <= curWdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench for data_sram_slave: directed vector table, reset and
// back-to-back sequences, and randomized traffic against a byte-level memory model.
module tb_data_sram_slave;

    localparam int LAT0 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addrOk, dataOk, err;
    logic [31:0] rdata;

    logic        req1, wr1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1;
    logic        addrOk1, dataOk1, err1;
    logic [31:0] rdata1;

    data_sram_slave #(.ADDR_W(12), .LATENCY(LAT0)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addrOk), .data_ok(dataOk), .rdata(rdata), .err(err)
    );

    data_sram_slave #(.ADDR_W(12), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
        .wdata(wdata1), .addr_ok(addrOk1), .data_ok(dataOk1), .rdata(rdata1), .err(err1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] refMem [int];

    function automatic bit refErr(input logic [1:0] sz, input logic [31:0] a);
        int nBytes;
        if (sz == 2'd3) return 1'b1;
        nBytes = 1 << sz;
        return (int'(a[1:0]) % nBytes) != 0;
    endfunction

    function automatic int wordIdx(input logic [31:0] a);
        return int'((a >> 2) % 32'd4096);
    endfunction

    task automatic refAccess(input bit w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] expRd,
                             output bit expErr, output bit rdKnown);
        int idx;
        int first;
        int n;
        logic [31:0] w32;
        idx = wordIdx(a);
        expErr = refErr(sz, a);
        expRd = 32'd0;
        rdKnown = 1'b1;
        if (!expErr) begin
            if (w) begin
                first = int'(a[1:0]);
                n = 1 << sz;
                w32 = refMem.exists(idx) ? refMem[idx] : 32'd0;
                for (int b = first; b < first + n; b++) w32[8*b +: 8] = d[8*b +: 8];
                refMem[idx] = w32;
                rdKnown = 1'b0;
            end else begin
                rdKnown = refMem.exists(idx);
                expRd = rdKnown ? refMem[idx] : 32'd0;
            end
        end
    endtask

    // ---------------- driver for the LATENCY=2 instance ----------------
    // called #1 after a rising edge; returns #1 after the edge that raised data_ok
    task automatic doTxn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] gotRd,
                         output logic gotErr, output int acceptWait,
                         output int respWait, output bit ok);
        ok = 1'b0; acceptWait = 0; respWait = 0; gotRd = 32'd0; gotErr = 1'b0;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        while (addrOk !== 1'b1) begin
            @(posedge clk); #1;
            acceptWait++;
            if (acceptWait > 50) begin
                req = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
        while (dataOk !== 1'b1) begin
            @(posedge clk); #1;
            respWait++;
            if (respWait > 50) return;
        end
        gotRd = rdata; gotErr = err; ok = 1'b1;
    endtask

    task automatic runTxn(input string name, input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] expRd, input bit expErr, input bit chkRd,
                          output int acceptWait);
        logic [31:0] gotRd;
        logic        gotErr;
        int          respWait;
        bit          ok;
        doTxn(w, sz, a, d, gotRd, gotErr, acceptWait, respWait, ok);
        if (!ok) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, "_lat"}, 32'(respWait), 32'(LAT0 - 1));
        check({name, "_err"}, {31'd0, gotErr}, {31'd0, expErr});
        if (chkRd) check({name, "_rdata"}, gotRd, expRd);
    endtask

    task automatic modelTxn(input string name, input bit w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        logic [31:0] expRd;
        bit          expErr;
        bit          rdKnown;
        int          aw;
        refAccess(w, sz, a, d, expRd, expErr, rdKnown);
        runTxn(name, w, sz, a, d, expRd, expErr, rdKnown || expErr, aw);
    endtask

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expRd;
        bit          expErr;
        bit          chkRd;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int aw;
        int waitCnt;
        logic [31:0] vals [4];

        vecs[0]  = '{1'b1, 2'd2, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 2'd2, 32'h200,  32'h11223344, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 32'h202,  32'h00AB0000, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 32'h200,  32'h0,        32'h11AB3344, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 2'd1, 32'h101,  32'h12345678, 32'h0,        1'b1, 1'b1};
        vecs[6]  = '{1'b0, 2'd2, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 2'd1, 32'h102,  32'hCAFE0000, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 32'h100,  32'h0,        32'hCAFEBEEF, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'd3, 32'h100,  32'h0,        32'h0,        1'b1, 1'b1};
        vecs[10] = '{1'b0, 2'd2, 32'h4100, 32'h0,        32'hCAFEBEEF, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'd2, 32'h102,  32'h0,        32'h0,        1'b1, 1'b1};
        vecs[12] = '{1'b1, 2'd0, 32'h103,  32'h77000000, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 32'h101,  32'h0,        32'h77FEBEEF, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 2'd2, 32'h202,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b1};
        vecs[15] = '{1'b1, 2'd1, 32'h200,  32'h0000BEAD, 32'h0,        1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'd2, 32'h200,  32'h0,        32'h11ABBEAD, 1'b0, 1'b1};

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; wr1 = 1'b0; size1 = 2'd0; addr1 = 32'd0; wdata1 = 32'd0;

        // reset held for two edges
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_data_ok", {31'd0, dataOk}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst1_data_ok", {31'd0, dataOk1}, 32'd0);
`ifdef DSRAM_BACKPRESSURE_EN
        check("rst_addr_ok_0", {31'd0, addrOk}, 32'd0);
        @(posedge clk); #1;
        check("bp_addr_ok_1", {31'd0, addrOk}, 32'd1);
        @(posedge clk); #1;
        check("bp_addr_ok_2", {31'd0, addrOk}, 32'd0);
        @(posedge clk); #1;
        check("bp_addr_ok_3", {31'd0, addrOk}, 32'd1);
`else
        check("rst_addr_ok", {31'd0, addrOk}, 32'd1);
        check("rst1_addr_ok", {31'd0, addrOk1}, 32'd1);
`endif

        // directed vectors, issued back-to-back
        for (int i = 0; i < 17; i++) begin
            runTxn($sformatf("row%0d", i), vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d,
                   vecs[i].expRd, vecs[i].expErr, vecs[i].chkRd, aw);
`ifndef DSRAM_BACKPRESSURE_EN
            check($sformatf("row%0d_b2b_accept", i), 32'(aw), 32'd0);
`endif
        end

        // restore a known word then store over it and reset on the RESP-entry edge
        runTxn("rw_prep", 1'b1, 2'd2, 32'h100, 32'h77FEBEEF, 32'h0, 1'b0, 1'b0, aw);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h100; wdata = 32'h55555555;
        waitCnt = 0;
        while (addrOk !== 1'b1 && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        check("rstw_wait_dok", {31'd0, dataOk}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstw_dok0", {31'd0, dataOk}, 32'd0);
        check("rstw_rdata", rdata, 32'd0);
        check("rstw_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rstw_dok%0d", i + 1), {31'd0, dataOk}, 32'd0);
        end
        runTxn("rstw_load", 1'b0, 2'd2, 32'h100, 32'h0, 32'h77FEBEEF, 1'b0, 1'b1, aw);

`ifndef DSRAM_BACKPRESSURE_EN
        // LATENCY=1: four stores then four loads, one data_ok every cycle
        vals[0] = 32'hA0A1A2A3; vals[1] = 32'hB0B1B2B3;
        vals[2] = 32'hC0C1C2C3; vals[3] = 32'hD0D1D2D3;
        check("l1_idle_addr_ok", {31'd0, addrOk1}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            req1 = 1'b1; wr1 = (i < 4); size1 = 2'd2;
            addr1 = 32'h40 + 32'(4 * (i % 4)); wdata1 = vals[i % 4];
            @(posedge clk); #1;
            check($sformatf("l1_dok%0d", i), {31'd0, dataOk1}, 32'd1);
            if (i >= 4) begin
                check($sformatf("l1_rdata%0d", i), rdata1, vals[i - 4]);
                check($sformatf("l1_err%0d", i), {31'd0, err1}, 32'd0);
            end
        end
        req1 = 1'b0;
        @(posedge clk); #1;
        check("l1_dok_end", {31'd0, dataOk1}, 32'd0);
`endif

        // randomized traffic over eight preloaded words with aliased upper bits
        for (int i = 0; i < 8; i++)
            modelTxn($sformatf("pre%0d", i), 1'b1, 2'd2, 32'(32'hC00 + 4 * i), $urandom);
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 15)) << 14) | (32'(32'h300 + $urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            modelTxn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
